// File: rtl/id_ex_operand_stage_pkg.sv
// rtl/id_ex_operand_stage_pkg.sv - shared ALU codes, ALUOp encodings and funct constants
package id_ex_operand_stage_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_NOP = 4'd15;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALUOp + funct to 4-bit ALU code
module alu_ctrl_decode
    import id_ex_operand_stage_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_NOP;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_OR:  alu_control = ALU_OR;
            default: begin
                // unknown R-type funct falls to NOP so the ALU yields 0
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_NOR: alu_control = ALU_NOR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   alu_control = ALU_NOP;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register with forwarding and operand select for the ALU
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic              id_alu_src,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              exmem_wr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_val,
    input  logic              memwb_wr,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_val,
    output logic              ex_valid,
    output logic [3:0]        alu_control,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd
);

    // EX/MEM has priority over MEM/WB; register 0 is hardwired and never forwarded
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_AW-1:0] idx,
        input logic [DATA_W-1:0] reg_val,
        input logic              em_wr,
        input logic [REG_AW-1:0] em_rd,
        input logic [DATA_W-1:0] em_val,
        input logic              mw_wr,
        input logic [REG_AW-1:0] mw_rd,
        input logic [DATA_W-1:0] mw_val
    );
        if (em_wr && (em_rd != '0) && (em_rd == idx))
            return em_val;
        else if (mw_wr && (mw_rd != '0) && (mw_rd == idx))
            return mw_val;
        else
            return reg_val;
    endfunction

    logic [3:0]        dec_code;
    logic [3:0]        ex_code;
    logic              ex_alu_src;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd_q;
    logic [DATA_W-1:0] ex_rs_val;
    logic [DATA_W-1:0] ex_rt_val;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    alu_ctrl_decode u_alu_ctrl_decode (
        .alu_op      (id_alu_op),
        .funct       (id_funct),
        .alu_control (dec_code)
    );

    // flush leaves an AND 0,0 bubble; stall holds every field
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            ex_valid   <= 1'b0;
            ex_code    <= ALU_AND;
            ex_alu_src <= 1'b0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd_q    <= '0;
            ex_rs_val  <= '0;
            ex_rt_val  <= '0;
            ex_imm     <= '0;
        end else if (!stall) begin
            ex_valid   <= id_valid;
            ex_code    <= dec_code;
            ex_alu_src <= id_alu_src;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd_q    <= id_rd;
            ex_rs_val  <= id_rs_val;
            ex_rt_val  <= id_rt_val;
            ex_imm     <= id_imm;
        end
    end

    always_comb begin
        fwd_rs = fwd_sel(ex_rs, ex_rs_val, exmem_wr, exmem_rd, exmem_val,
                         memwb_wr, memwb_rd, memwb_val);
        fwd_rt = fwd_sel(ex_rt, ex_rt_val, exmem_wr, exmem_rd, exmem_val,
                         memwb_wr, memwb_rd, memwb_val);
    end

    assign alu_control   = ex_code;
    assign ex_rd         = ex_rd_q;
    assign alu_a         = ex_valid ? fwd_rs : '0;
    assign alu_b         = ex_valid ? (ex_alu_src ? ex_imm : fwd_rt) : '0;
    assign ex_store_data = ex_valid ? fwd_rt : '0;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed and random checks of id_ex_operand_stage against a reference model
module tb_id_ex_operand_stage;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic        stall;
    logic        flush;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_alu_src;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic [31:0] id_imm;
    logic        exmem_wr;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_val;
    logic        memwb_wr;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_val;
    logic        ex_valid;
    logic [3:0]  alu_control;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;

    int errors = 0;
    int checks = 0;

    // reference model of the instruction sitting in EX
    logic        m_valid;
    logic [3:0]  m_code;
    logic        m_src;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_rsv, m_rtv, m_imm;

    id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .stall(stall), .flush(flush),
        .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_val(exmem_val),
        .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_val(memwb_val),
        .ex_valid(ex_valid), .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] code_of(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'd0) return 4'd2;
        if (op == 2'd1) return 4'd6;
        if (op == 2'd3) return 4'd1;
        case (fn)
            6'h20: return 4'd2;
            6'h22: return 4'd6;
            6'h24: return 4'd0;
            6'h25: return 4'd1;
            6'h27: return 4'd12;
            6'h2A: return 4'd7;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] exp_fwd(input logic [4:0] idx, input logic [31:0] v);
        if (exmem_wr && exmem_rd != 5'd0 && exmem_rd == idx) return exmem_val;
        if (memwb_wr && memwb_rd != 5'd0 && memwb_rd == idx) return memwb_val;
        return v;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_code = 0; m_src = 0; m_rs = 0; m_rt = 0; m_rd = 0;
        m_rsv = 0; m_rtv = 0; m_imm = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ea, eb, es;
        ea = m_valid ? exp_fwd(m_rs, m_rsv) : 32'd0;
        es = m_valid ? exp_fwd(m_rt, m_rtv) : 32'd0;
        eb = m_valid ? (m_src ? m_imm : es) : 32'd0;
        chk({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
        chk({tag, ".code"},  32'(alu_control), 32'(m_code));
        chk({tag, ".a"},     alu_a, ea);
        chk({tag, ".b"},     alu_b, eb);
        chk({tag, ".store"}, ex_store_data, es);
        chk({tag, ".rd"},    32'(ex_rd), 32'(m_rd));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (reset || flush) model_clear();
        else if (!stall) begin
            m_valid = id_valid; m_code = code_of(id_alu_op, id_funct); m_src = id_alu_src;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            m_rsv = id_rs_val; m_rtv = id_rt_val; m_imm = id_imm;
        end
        #1;
        check_all(tag);
    endtask

    task automatic set_id(input logic [1:0] op, input logic [5:0] fn, input logic src,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsv, input logic [31:0] rtv, input logic [31:0] imm);
        id_valid = 1; id_alu_op = op; id_funct = fn; id_alu_src = src;
        id_rs = rs; id_rt = rt; id_rd = rd; id_rs_val = rsv; id_rt_val = rtv; id_imm = imm;
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0;
        set_id(2'd0, 6'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        id_valid = 0;
        exmem_wr = 0; exmem_rd = 0; exmem_val = 0;
        memwb_wr = 0; memwb_rd = 0; memwb_val = 0;
        model_clear();
        #2;
        check_all("reset_init");
        @(posedge clk); #1;
        reset = 0;

        // NOR with operands from the register file
        set_id(2'd2, 6'h27, 0, 5'd5, 5'd6, 5'd9, 32'hF0, 32'h0F, 32'h0);
        step("nor_load");
        chk("nor_code_const", 32'(alu_control), 32'd12);
        chk("nor_a_const", alu_a, 32'hF0);

        // forwarding priority on rs
        set_id(2'd0, 6'h00, 0, 5'd3, 5'd4, 5'd1, 32'h11, 32'h22, 32'h0);
        exmem_wr = 1; exmem_rd = 3; exmem_val = 32'hAA;
        memwb_wr = 1; memwb_rd = 3; memwb_val = 32'hBB;
        step("fwd_both");
        chk("fwd_exmem_const", alu_a, 32'hAA);
        exmem_wr = 0; #1;
        check_all("fwd_memwb");
        chk("fwd_memwb_const", alu_a, 32'hBB);
        set_id(2'd0, 6'h00, 0, 5'd0, 5'd0, 5'd2, 32'h33, 32'h44, 32'h0);
        exmem_wr = 1; exmem_rd = 0; memwb_rd = 0;
        step("fwd_r0");
        chk("fwd_r0_const", alu_a, 32'h33);

        // immediate on B, forwarded rt to store data
        set_id(2'd0, 6'h00, 1, 5'd8, 5'd7, 5'd7, 32'h5, 32'h6, 32'hFFFFFFFC);
        exmem_wr = 0; memwb_wr = 1; memwb_rd = 7; memwb_val = 32'h10;
        step("imm_src");
        chk("imm_b_const", alu_b, 32'hFFFFFFFC);
        chk("imm_store_const", ex_store_data, 32'h10);
        chk("imm_code_const", 32'(alu_control), 32'd2);

        // stall holds fields while forwarding tracks live sources
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(2'($urandom), 6'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), $urandom, $urandom, $urandom);
            memwb_val = 32'h100 + 32'(i);
            step("stall_hold");
            chk("stall_rd_const", 32'(ex_rd), 32'd7);
        end
        flush = 1;
        step("stall_flush");
        chk("flush_valid_const", 32'(ex_valid), 32'd0);
        stall = 0; flush = 0;

        // remaining decode cases
        set_id(2'd2, 6'h08, 0, 5'd1, 5'd2, 5'd3, 1, 2, 0);
        step("code_nop");
        set_id(2'd1, 6'h08, 0, 5'd1, 5'd2, 5'd3, 1, 2, 0);
        step("code_sub");
        set_id(2'd3, 6'h20, 0, 5'd1, 5'd2, 5'd3, 1, 2, 0);
        step("code_or");

        // random traffic with narrow register indices to exercise forwarding hits
        for (int i = 0; i < 200; i++) begin
            logic [5:0] fn;
            case ($urandom_range(0, 6))
                0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
                4: fn = 6'h27; 5: fn = 6'h2A; default: fn = 6'($urandom);
            endcase
            set_id(2'($urandom), fn, 1'($urandom), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom), $urandom, $urandom, $urandom);
            id_valid = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 8) == 0);
            exmem_wr = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_val = $urandom;
            memwb_wr = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_val = $urandom;
            step("rand");
            exmem_val = $urandom; memwb_wr = 1'($urandom); #1;
            check_all("rand_comb");
        end
        stall = 0; flush = 0;

        // asynchronous reset mid-run wins over stall and flush
        set_id(2'd0, 6'h00, 0, 5'd2, 5'd3, 5'd4, 32'h77, 32'h88, 0);
        exmem_wr = 0; memwb_wr = 0;
        step("pre_reset");
        chk("pre_reset_valid_const", 32'(ex_valid), 32'd1);
        stall = 1; flush = 1;
        #2 reset = 1;
        #1;
        model_clear();
        check_all("reset_async");
        step("reset_hold");
        reset = 0; stall = 0; flush = 0;
        set_id(2'd2, 6'h2A, 0, 5'd2, 5'd3, 5'd4, 32'h1, 32'h2, 0);
        step("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
